// File: rtl/tri_bus_arbiter_pkg.sv
// Shared types and default sizing for the tri-state bus arbiter.
package tri_bus_arbiter_pkg;

  localparam int N_DEF        = 4;
  localparam int W_DEF        = 8;
  localparam int MAX_HOLD_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_e;

endpackage

// File: rtl/tri_bus_arbiter_bus_driver.sv
// W-bit tri-state driver; drives y from a while en is high, otherwise floats.
module bus_driver #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic         en,
  output tri   [W-1:0] y
);

  assign y = en ? a : {W{1'bz}};

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter granting one of N requesters a shared tri-state bus,
// with a bounded hold time and a one-cycle turnaround between owners.
module tri_bus_arbiter
  import tri_bus_arbiter_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int W        = W_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       din,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output tri   [W-1:0]         bus
);

  localparam int IW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD);

  state_e          state_q;
  logic [N-1:0]    grant_q;
  logic [IW-1:0]   owner_q;
  logic [IW-1:0]   last_q;
  logic [HW-1:0]   hold_q;

  logic            win_vld_d;
  logic [IW-1:0]   win_d;
  logic [IW-1:0]   idx;

  // Search starts just after the previous owner, so a forced-release owner
  // that keeps requesting is considered last.
  always_comb begin
    win_vld_d = 1'b0;
    win_d     = '0;
    idx       = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last_q) + k) % N);
      if (!win_vld_d && req[idx]) begin
        win_vld_d = 1'b1;
        win_d     = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      hold_q  <= '0;
      last_q  <= IW'(N - 1);
    end else begin
      case (state_q)
        IDLE, TURN: begin
          if (win_vld_d) begin
            state_q <= OWN;
            grant_q <= N'(1) << win_d;
            owner_q <= win_d;
            last_q  <= win_d;
            hold_q  <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        OWN: begin
          if (!req[owner_q] || hold_q == HW'(MAX_HOLD - 1)) begin
            state_q <= TURN;
            grant_q <= '0;
            owner_q <= '0;
            hold_q  <= '0;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          owner_q <= '0;
          hold_q  <= '0;
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign owner = owner_q;
  assign busy  = (state_q != IDLE);

  // Enables come straight from the grant flops, keeping the bus glitch-free.
  for (genvar i = 0; i < N; i++) begin : g_drv
    bus_driver #(.W(W)) u_drv (
      .a  (din[i*W +: W]),
      .en (grant_q[i]),
      .y  (bus)
    );
  end

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Scoreboard bench for tri_bus_arbiter; an undriven bus reads as all ones via pullups.
module tb_tri_bus_arbiter;

  localparam int N        = 4;
  localparam int W        = 8;
  localparam int MAX_HOLD = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] din;
  wire  [3:0]  grant;
  wire  [1:0]  owner;
  wire         busy;
  tri   [7:0]  bus;

  always #5 clk = ~clk;

  for (genvar b = 0; b < W; b++) begin : g_pu
    pullup (bus[b]);
  end

  tri_bus_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .din   (din),
    .grant (grant),
    .owner (owner),
    .busy  (busy),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic [7:0] bus;
  } exp_t;

  exp_t       sb[$];
  int         n_chk = 0;
  int         n_err = 0;

  int         m_state, m_owner, m_last, m_hold;
  logic [3:0] m_grant;

  bit         rec;
  logic [3:0] runs_v[$];
  int         runs_n[$];
  logic [3:0] ev[9];
  int         el[9];
  logic [3:0] rnd_req;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= N; k++)
      if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic model_edge(input logic r_rst, input logic [3:0] r_req);
    int w;
    if (r_rst) begin
      m_state = 0; m_grant = '0; m_owner = 0; m_hold = 0; m_last = N - 1;
    end else begin
      case (m_state)
        1: begin
          if (!r_req[m_owner] || m_hold == MAX_HOLD - 1) begin
            m_state = 2; m_grant = '0; m_owner = 0; m_hold = 0;
          end else begin
            m_hold++;
          end
        end
        default: begin
          w = rr_pick(r_req, m_last);
          if (w >= 0) begin
            m_state = 1; m_owner = w; m_last = w; m_hold = 0; m_grant = 4'b0001 << w;
          end else begin
            m_state = 0;
          end
        end
      endcase
    end
  endtask

  task automatic step(input logic r_rst, input logic [3:0] r_req, input logic [31:0] r_din);
    exp_t e;
    @(negedge clk);
    rst = r_rst;
    req = r_req;
    din = r_din;
    model_edge(r_rst, r_req);
    e.grant = m_grant;
    e.owner = 2'(m_owner);
    e.busy  = (m_state != 0);
    e.bus   = (m_grant != 0) ? r_din[m_owner*8 +: 8] : 8'hFF;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("grant", 32'(grant), 32'(e.grant));
    chk("owner", 32'(owner), 32'(e.owner));
    chk("busy", 32'(busy), 32'(e.busy));
    chk("bus", 32'(bus), 32'(e.bus));
    chk("onehot", 32'($countones(grant) <= 1), 32'd1);
    if (rec) begin
      if (runs_v.size() > 0 && runs_v[runs_v.size()-1] == grant)
        runs_n[runs_n.size()-1]++;
      else begin
        runs_v.push_back(grant);
        runs_n.push_back(1);
      end
    end
  endtask

  task automatic chk_runs(input string tag, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      if (i < runs_v.size()) begin
        chk({tag, "_val"}, 32'(runs_v[i]), 32'(ev[i]));
        chk({tag, "_len"}, 32'(runs_n[i]), 32'(el[i]));
      end else begin
        chk({tag, "_missing"}, 32'(runs_v.size()), 32'(i + 1));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    din = '0;
    rec = 1'b0;

    // Reset with no requests
    step(1'b1, 4'b0000, 32'h0);
    step(1'b1, 4'b0000, 32'h0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bus", 32'(bus), 32'hFF);
    chk("rst_owner", 32'(owner), 32'd0);

    // Single requester: grant, hold, drop, turnaround, idle
    step(1'b0, 4'b0000, 32'h000000A5);
    step(1'b0, 4'b0000, 32'h000000A5);
    step(1'b0, 4'b0001, 32'h000000A5);
    chk("r0_grant", 32'(grant), 32'd1);
    chk("r0_bus", 32'(bus), 32'hA5);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0001, 32'h000000A5);
    step(1'b0, 4'b0000, 32'h000000A5);
    chk("r0_turn_grant", 32'(grant), 32'd0);
    chk("r0_turn_busy", 32'(busy), 32'd1);
    step(1'b0, 4'b0000, 32'h000000A5);
    chk("r0_idle_busy", 32'(busy), 32'd0);

    // All requesting: 16-cycle slots in round-robin order, one gap each
    step(1'b1, 4'b0000, 32'h0);
    runs_v.delete(); runs_n.delete(); rec = 1'b1;
    for (int i = 0; i < 84; i++) step(1'b0, 4'b1111, 32'h44332211);
    rec = 1'b0;
    ev = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    el = '{16, 1, 16, 1, 16, 1, 16, 1, 16};
    chk_runs("rr", 9);

    // Lone requester is forced off after 16 cycles and re-granted after one gap
    step(1'b1, 4'b0000, 32'h0);
    runs_v.delete(); runs_n.delete(); rec = 1'b1;
    for (int i = 0; i < 40; i++) step(1'b0, 4'b0100, 32'h005A0000);
    rec = 1'b0;
    ev = '{4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    el = '{16, 1, 16, 1, 6, 0, 0, 0, 0};
    chk_runs("hold", 5);

    // Reset during ownership of requester 2
    step(1'b1, 4'b0000, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0100, 32'h00C30000);
    chk("own2_grant", 32'(grant), 32'd4);
    step(1'b1, 4'b0100, 32'h00C30000);
    chk("rstown_grant", 32'(grant), 32'd0);
    chk("rstown_bus", 32'(bus), 32'hFF);
    step(1'b0, 4'b0101, 32'h00C3003C);
    chk("rstown_next_owner", 32'(owner), 32'd0);
    chk("rstown_next_grant", 32'(grant), 32'd1);

    // Simultaneous requests 1 and 3 with last owner 2
    step(1'b1, 4'b0000, 32'h0);
    step(1'b0, 4'b0100, 32'h77665544);
    step(1'b0, 4'b0000, 32'h77665544);
    step(1'b0, 4'b0000, 32'h77665544);
    step(1'b0, 4'b1010, 32'h77665544);
    chk("pri_first", 32'(grant), 32'd8);
    step(1'b0, 4'b1010, 32'h77665544);
    step(1'b0, 4'b0010, 32'h77665544);
    chk("pri_turn", 32'(grant), 32'd0);
    step(1'b0, 4'b0010, 32'h77665544);
    chk("pri_second", 32'(grant), 32'd2);
    chk("pri_second_bus", 32'(bus), 32'h55);

    // Random sticky requests with occasional reset
    rnd_req = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rnd_req = 4'($urandom);
      step(($urandom_range(0, 49) == 0), rnd_req, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tri_bus_arbiter.md
TRI_BUS_ARBITER -- requirements
Module: tri_bus_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the number of requesters sharing the bus.
REQ-002 The block SHALL have parameter W, default 8, meaning the shared bus width.
REQ-003 The block SHALL have parameter MAX_HOLD, default 16, meaning the maximum consecutive ownership cycles per grant.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port req, input, N bits: request bit i from requester i.
REQ-007 The block SHALL have port din, input, N*W bits: requester i data in slice [i*W +: W].
REQ-008 The block SHALL have port grant, output, N bits: registered one-hot ownership, or all zero.
REQ-009 The block SHALL have port owner, output, clog2(N) bits: index of the current owner; 0 when no owner.
REQ-010 The block SHALL have port busy, output, 1 bit: high while the state is OWN or TURN.
REQ-011 The block SHALL have port bus, output, W bits, tri-state: din slice of the owner, else all bits Z.

Function
REQ-012 The state machine SHALL have exactly three states: IDLE, OWN and TURN.
REQ-013 In IDLE, if any req bit is set at edge t, the block SHALL select a winner, enter OWN and assert that winner's grant from cycle t+1; the grant latency is 1 cycle.
REQ-014 The winner SHALL be chosen round-robin: search order starts at last_owner+1, increments modulo N, and the first set req bit wins.
REQ-015 In OWN, the bus SHALL carry din[owner], combinationally from din while grant is held.
REQ-016 OWN SHALL be left at the edge where req[owner] is sampled low, or where hold_cnt equals MAX_HOLD-1 (forced release).
REQ-017 When OWN is left, the block SHALL enter TURN, clearing grant and driving bus Z for exactly one cycle.
REQ-018 From TURN, the block SHALL go directly to OWN with a new round-robin winner if any req bit is set; otherwise it SHALL go to IDLE.
REQ-019 A forced-release owner that still requests SHALL be eligible again only after the other requesters in round-robin order; with no other requesters it SHALL be re-granted after the one TURN cycle.
REQ-020 hold_cnt SHALL reset to 0 on entry to OWN, increment once per OWN cycle, and never exceed MAX_HOLD-1.
REQ-021 grant SHALL never have more than one bit set, and bus SHALL never be driven in IDLE or TURN.
REQ-022 last_owner SHALL update to the winner on every entry to OWN.
REQ-023 req changes on non-owner bits during OWN SHALL have no effect until the next arbitration point.
REQ-024 The bus enable SHALL be decoded from the registered grant only, never from req, so the driven bus is glitch-free.

Reset
REQ-025 While rst is high at a clock edge, the block SHALL load state IDLE, grant 0, owner 0, busy 0, hold_cnt 0, last_owner N-1 (so requester 0 has first priority) and bus all Z.
REQ-026 Reset asserted mid-OWN SHALL release the bus at that same edge, with no TURN cycle.

Structure
REQ-027 A shared package SHALL hold the state enumeration (IDLE/OWN/TURN) and the default values of N, W and MAX_HOLD.
REQ-028 The block SHALL instantiate one sub-module, bus_driver (a W-bit tri-state driver with input a, enable en and output y), once per requester, with enable grant[i].
REQ-029 The round-robin select SHALL be a purely combinational function of req and last_owner; the state machine, hold_cnt and last_owner SHALL be the only registers apart from grant and owner.

Verification
REQ-030 The bench SHALL check: rst high for 2 cycles, req=0 -> grant=0, busy=0, bus=Z, owner=0.
REQ-031 The bench SHALL check: req=0001 at cycle 5, din0=8'hA5 -> grant=0001 and bus=8'hA5 from cycle 6; req dropped at cycle 9 -> grant=0 and bus=Z at cycle 10 (TURN), IDLE at cycle 11.
REQ-032 The bench SHALL check: req=1111 held constantly -> grants 0001, 0010, 0100, 1000, 0001 in order, each lasting 16 cycles and separated by one Z cycle.
REQ-033 The bench SHALL check: req=0100 held alone for 40 cycles -> OWN for 16 cycles, one TURN cycle, then re-grant of 0100; at no cycle is more than one grant bit set.
REQ-034 The bench SHALL check: rst pulsed during OWN of requester 2 -> grant=0 and bus=Z at the next edge; the next arbitration favours requester 0.
REQ-035 The bench SHALL check: req 0010 and 1000 rising in the same cycle with last_owner=2 -> 1000 is granted first, then 0010 after TURN.
